// File: rtl/tick_period_monitor_if.sv
// tick_period_monitor_if: control inputs and status outputs of the tick period monitor.
// The master side is the tick source and its supervisor; the slave side is the monitor.
// Defining TICK_MINMAX_EN adds the period_min/period_max status signals.
interface tick_period_monitor_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             tick_in;
  logic [WIDTH-1:0] expected;
  logic             clear;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             fault;
  logic             timeout;
`ifdef TICK_MINMAX_EN
  logic [WIDTH-1:0] period_min;
  logic [WIDTH-1:0] period_max;

  modport master (
    output enable, tick_in, expected, clear,
    input  period, period_valid, locked, fault, timeout, period_min, period_max
  );
  modport slave (
    input  enable, tick_in, expected, clear,
    output period, period_valid, locked, fault, timeout, period_min, period_max
  );
`else
  modport master (
    output enable, tick_in, expected, clear,
    input  period, period_valid, locked, fault, timeout
  );
  modport slave (
    input  enable, tick_in, expected, clear,
    output period, period_valid, locked, fault, timeout
  );
`endif
endinterface

// File: rtl/tick_period_monitor.sv
// tick_period_monitor: measures the clock count between consecutive tick strobes,
// compares it with expected +/- TOL, declares lock after LOCK_CNT good periods and
// raises a sticky fault on an early, late or missing tick once locked.
// Optional feature: define TICK_MINMAX_EN to track the minimum and maximum period.
module tick_period_monitor #(
  parameter int WIDTH    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 0
) (
  input logic                  clk,
  input logic                  reset,
  tick_period_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_TRACK   = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [WIDTH:0]   TOL_W   = (WIDTH+1)'(TOL);
  localparam logic [7:0]       LOCK_W  = 8'(LOCK_CNT);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic [7:0]       good_cnt_r;
  logic [7:0]       good_nxt_s;
  logic [WIDTH-1:0] period_r;
  logic             period_valid_r;
  logic             locked_r;
  logic             fault_r;
  logic             timeout_r;
  logic             timed_out_r;

  logic [WIDTH:0]   exp_w_s;
  logic [WIDTH:0]   low_s;
  logic [WIDTH:0]   high_s;
  logic [WIDTH:0]   meas_s;
  logic [WIDTH-1:0] meas_sat_s;
  logic             in_win_s;
  logic             measuring_s;
  logic             clear_acc_s;
  logic             tick_acc_s;
  logic             pv_nxt_s;
  logic             timeout_s;

  // Tolerance window and the period a tick would measure this cycle, in WIDTH+1 bits
  always_comb begin
    exp_w_s = {1'b0, bus.expected};
    high_s  = exp_w_s + TOL_W;
    if (exp_w_s >= TOL_W) begin
      low_s = exp_w_s - TOL_W;
    end else begin
      low_s = {(WIDTH+1){1'b0}};
    end
    meas_s = {1'b0, cnt_r} + {{WIDTH{1'b0}}, 1'b1};
    if (meas_s[WIDTH]) begin
      meas_sat_s = CNT_MAX;
    end else begin
      meas_sat_s = meas_s[WIDTH-1:0];
    end
    in_win_s = (meas_s >= low_s) && (meas_s <= high_s);
  end

  // Tick acceptance, saturating interval counter and look-ahead timeout detection
  always_comb begin
    measuring_s = (state_r == ST_TRACK) || (state_r == ST_LOCKED) || (state_r == ST_FAULT);
    clear_acc_s = bus.enable && bus.clear && (state_r != ST_IDLE);
    tick_acc_s  = bus.enable && !bus.clear && bus.tick_in && (state_r != ST_IDLE);
    pv_nxt_s    = tick_acc_s && measuring_s;
    if (!bus.enable || (state_r == ST_IDLE)) begin
      cnt_nxt_s = {WIDTH{1'b0}};
    end else if (tick_acc_s) begin
      cnt_nxt_s = {WIDTH{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
    // Registered so that timeout is high in the cycle whose cnt equals the high bound.
    timeout_s = bus.enable && !bus.clear && !tick_acc_s && measuring_s && !timed_out_r &&
                ({1'b0, cnt_nxt_s} == high_s);
  end

  // Next-state logic: enable low beats clear, which beats tick
  always_comb begin
    state_nxt_s = state_r;
    good_nxt_s  = good_cnt_r;
    if (!bus.enable) begin
      state_nxt_s = ST_IDLE;
      good_nxt_s  = 8'd0;
    end else if (clear_acc_s) begin
      state_nxt_s = ST_ACQUIRE;
      good_nxt_s  = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (tick_acc_s) begin
            state_nxt_s = ST_TRACK;
            good_nxt_s  = 8'd0;
          end else begin
            state_nxt_s = ST_ACQUIRE;
          end
        end
        ST_TRACK: begin
          if (tick_acc_s && in_win_s) begin
            good_nxt_s = good_cnt_r + 8'd1;
            if ((good_cnt_r + 8'd1) >= LOCK_W) begin
              state_nxt_s = ST_LOCKED;
            end else begin
              state_nxt_s = ST_TRACK;
            end
          end else if (tick_acc_s) begin
            good_nxt_s = 8'd0;
          end else if (timeout_s) begin
            state_nxt_s = ST_ACQUIRE;
            good_nxt_s  = 8'd0;
          end else begin
            state_nxt_s = ST_TRACK;
          end
        end
        ST_LOCKED: begin
          if ((tick_acc_s && !in_win_s) || timeout_s) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          good_nxt_s  = 8'd0;
        end
      endcase
    end
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {WIDTH{1'b0}};
      good_cnt_r     <= 8'd0;
      period_r       <= {WIDTH{1'b0}};
      period_valid_r <= 1'b0;
      locked_r       <= 1'b0;
      fault_r        <= 1'b0;
      timeout_r      <= 1'b0;
      timed_out_r    <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      good_cnt_r     <= good_nxt_s;
      period_valid_r <= pv_nxt_s;
      locked_r       <= (state_nxt_s == ST_LOCKED);
      fault_r        <= (state_nxt_s == ST_FAULT);
      timeout_r      <= timeout_s;
      if (pv_nxt_s) begin
        period_r <= meas_sat_s;
      end
      if (!bus.enable || bus.clear || tick_acc_s) begin
        timed_out_r <= 1'b0;
      end else if (timeout_s) begin
        timed_out_r <= 1'b1;
      end
    end
  end

  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;
  assign bus.locked       = locked_r;
  assign bus.fault        = fault_r;
  assign bus.timeout      = timeout_r;

`ifdef TICK_MINMAX_EN
  logic [WIDTH-1:0] period_min_r;
  logic [WIDTH-1:0] period_max_r;

  // Running extremes of reported periods; restarted by reset and clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_min_r <= {WIDTH{1'b1}};
      period_max_r <= {WIDTH{1'b0}};
    end else if (clear_acc_s) begin
      period_min_r <= {WIDTH{1'b1}};
      period_max_r <= {WIDTH{1'b0}};
    end else if (pv_nxt_s) begin
      if (meas_sat_s < period_min_r) begin
        period_min_r <= meas_sat_s;
      end
      if (meas_sat_s > period_max_r) begin
        period_max_r <= meas_sat_s;
      end
    end
  end

  assign bus.period_min = period_min_r;
  assign bus.period_max = period_max_r;
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// tb_tick_period_monitor: drives two monitors (TOL=0 and TOL=1) with identical stimulus
// and checks them against a timestamp-based reference model plus directed expectations.
module tb_tick_period_monitor;

  localparam int LOCK = 4;
  localparam logic [2:0] M_IDLE = 3'd0, M_ACQ = 3'd1, M_TRACK = 3'd2, M_LOCK = 3'd3, M_FAULT = 3'd4;

  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] last;
    logic [7:0]  good;
    logic [15:0] period;
    logic [15:0] pmin;
    logic [15:0] pmax;
    logic        pv;
    logic        locked;
    logic        fault;
    logic        to;
    logic        to_done;
  } mstate_t;

`ifdef TICK_MINMAX_EN
  localparam int OW = 52;
`else
  localparam int OW = 20;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        en_b, clr_b, tk_b;
  logic [15:0] exp_b;
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  mstate_t     m0, m1;
  logic [OW-1:0] obs0, obs1, exp0, exp1;

  tick_period_monitor_if #(.WIDTH(16)) bus0 ();
  tick_period_monitor_if #(.WIDTH(16)) bus1 ();

  assign bus0.enable = en_b;  assign bus0.clear = clr_b;
  assign bus0.tick_in = tk_b; assign bus0.expected = exp_b;
  assign bus1.enable = en_b;  assign bus1.clear = clr_b;
  assign bus1.tick_in = tk_b; assign bus1.expected = exp_b;

  tick_period_monitor #(.WIDTH(16), .LOCK_CNT(LOCK), .TOL(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  tick_period_monitor #(.WIDTH(16), .LOCK_CNT(LOCK), .TOL(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

`ifdef TICK_MINMAX_EN
  assign obs0 = {bus0.period, bus0.period_valid, bus0.locked, bus0.fault, bus0.timeout, bus0.period_min, bus0.period_max};
  assign obs1 = {bus1.period, bus1.period_valid, bus1.locked, bus1.fault, bus1.timeout, bus1.period_min, bus1.period_max};
  assign exp0 = {m0.period, m0.pv, m0.locked, m0.fault, m0.to, m0.pmin, m0.pmax};
  assign exp1 = {m1.period, m1.pv, m1.locked, m1.fault, m1.to, m1.pmin, m1.pmax};
`else
  assign obs0 = {bus0.period, bus0.period_valid, bus0.locked, bus0.fault, bus0.timeout};
  assign obs1 = {bus1.period, bus1.period_valid, bus1.locked, bus1.fault, bus1.timeout};
  assign exp0 = {m0.period, m0.pv, m0.locked, m0.fault, m0.to};
  assign exp1 = {m1.period, m1.pv, m1.locked, m1.fault, m1.to};
`endif

  always #5 clk = ~clk;

  function automatic mstate_t reset_state();
    mstate_t r;
    r = '0;
    r.pmin = 16'hFFFF;
    return r;
  endfunction

  // Reference: periods are differences of tick timestamps; timeout when the running
  // interval (time since the last tick) first exceeds expected+tol.
  function automatic mstate_t model_step(mstate_t s, int now, bit en, bit clr, bit tk, int expv, int tol);
    mstate_t n;
    int p, lo, hi;
    bit acc, win;
    n = s; n.pv = 1'b0; n.to = 1'b0;
    lo  = (expv > tol) ? expv - tol : 0;
    hi  = expv + tol;
    p   = now - int'(s.last);
    win = (p >= lo) && (p <= hi);
    acc = en && !clr && tk && (s.mode != M_IDLE);
    if (!en) begin
      n.mode = M_IDLE; n.good = 8'd0; n.to_done = 1'b0;
    end else if (clr && s.mode != M_IDLE) begin
      n.mode = M_ACQ; n.good = 8'd0; n.to_done = 1'b0; n.pmin = 16'hFFFF; n.pmax = 16'h0;
    end else if (s.mode == M_IDLE) begin
      n.mode = M_ACQ;
    end else if (acc) begin
      n.last = now; n.to_done = 1'b0;
      if (s.mode == M_ACQ) begin
        n.mode = M_TRACK; n.good = 8'd0;
      end else begin
        n.pv = 1'b1; n.period = p[15:0];
        if (p[15:0] < s.pmin) n.pmin = p[15:0];
        if (p[15:0] > s.pmax) n.pmax = p[15:0];
        if (s.mode == M_TRACK) begin
          if (win) begin
            n.good = s.good + 8'd1;
            if (n.good >= 8'(LOCK)) n.mode = M_LOCK;
          end else begin
            n.good = 8'd0;
          end
        end else if (s.mode == M_LOCK && !win) begin
          n.mode = M_FAULT;
        end
      end
    end else if (s.mode >= M_TRACK && !s.to_done && (now + 1 - int'(s.last)) == hi + 1) begin
      n.to = 1'b1; n.to_done = 1'b1;
      if (s.mode == M_TRACK) begin
        n.mode = M_ACQ; n.good = 8'd0;
      end else if (s.mode == M_LOCK) begin
        n.mode = M_FAULT;
      end
    end
    n.locked = (n.mode == M_LOCK);
    n.fault  = (n.mode == M_FAULT);
    return n;
  endfunction

  // Reference model advances on the same edges as the designs
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= reset_state(); m1 <= reset_state(); cyc <= 0;
    end else begin
      m0  <= model_step(m0, cyc, en_b, clr_b, tk_b, int'(exp_b), 0);
      m1  <= model_step(m1, cyc, en_b, clr_b, tk_b, int'(exp_b), 1);
      cyc <= cyc + 1;
    end
  end

  task automatic step(input bit tk, input bit en, input bit clr);
    @(negedge clk);
    tk_b = tk; en_b = en; clr_b = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1 || obs0[OW-1 -: 20] !== 20'd0 || obs1[OW-1 -: 20] !== 20'd0) begin
        errors++;
        $display("FAIL reset dut0=%h dut1=%h ref0=%h (status bits must be zero)", obs0, obs1, exp0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock();
    int nt = 0, pvs = 0, lock_at = -1;
    exp_b = 16'd10;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 7; t++) begin
      for (int k = 1; k <= 10; k++) begin
        step(k == 10, 1'b1, 1'b0);
        if (k == 10) nt++;
        if (bus0.period_valid) pvs++;
        if (bus0.locked && lock_at < 0) lock_at = nt;
        checks++;
        if (obs0 !== exp0 || obs1 !== exp1) begin
          errors++;
          $display("FAIL lock t=%0t dut0=%h ref0=%h dut1=%h ref1=%h", $time, obs0, exp0, obs1, exp1);
        end
      end
    end
    checks++;
    if (lock_at !== 5 || pvs !== 6 || bus0.period !== 16'd10) begin
      errors++;
      $display("FAIL lock_point lock_at=%0d pvs=%0d period=%0d required 5 6 10", lock_at, pvs, bus0.period);
    end
  endtask

  task automatic test_early();
    int nt = 0, lock_at = -1;
    for (int k = 1; k <= 9; k++) begin
      step(k == 9, 1'b1, 1'b0);
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        errors++;
        $display("FAIL early t=%0t dut0=%h ref0=%h dut1=%h ref1=%h", $time, obs0, exp0, obs1, exp1);
      end
    end
    checks++;
    if (bus0.period !== 16'd9 || bus0.fault !== 1'b1 || bus0.locked !== 1'b0 || bus1.locked !== 1'b1) begin
      errors++;
      $display("FAIL early_fault period=%0d fault=%b locked=%b locked1=%b required 9 1 0 1",
               bus0.period, bus0.fault, bus0.locked, bus1.locked);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (bus0.fault !== 1'b0 || obs0 !== exp0) begin
      errors++;
      $display("FAIL early_clear fault=%b required 0 dut0=%h ref0=%h", bus0.fault, obs0, exp0);
    end
    for (int t = 0; t < 6; t++) begin
      for (int k = 1; k <= 10; k++) begin
        step(k == 10, 1'b1, 1'b0);
        if (k == 10) nt++;
        if (bus0.locked && lock_at < 0) lock_at = nt;
        checks++;
        if (obs0 !== exp0 || obs1 !== exp1) begin
          errors++;
          $display("FAIL relock t=%0t dut0=%h ref0=%h dut1=%h ref1=%h", $time, obs0, exp0, obs1, exp1);
        end
      end
    end
    checks++;
    if (lock_at !== 5) begin
      errors++;
      $display("FAIL relock_point lock_at=%0d required 5", lock_at);
    end
  endtask

  task automatic test_timeout();
    int n0 = 0, n1 = 0, g0 = -1, g1 = -1;
    for (int j = 1; j <= 25; j++) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus0.timeout) begin n0++; if (g0 < 0) g0 = j + 1; end
      if (bus1.timeout) begin n1++; if (g1 < 0) g1 = j + 1; end
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        errors++;
        $display("FAIL timeout t=%0t dut0=%h ref0=%h dut1=%h ref1=%h", $time, obs0, exp0, obs1, exp1);
      end
    end
    checks++;
    if (n0 !== 1 || g0 !== 11 || n1 !== 1 || g1 !== 12 || bus0.fault !== 1'b1 || bus1.fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout_gap n0=%0d g0=%0d n1=%0d g1=%0d f0=%b f1=%b required 1 11 1 12 1 1",
               n0, g0, n1, g1, bus0.fault, bus1.fault);
    end
  endtask

  task automatic test_tol();
    int ivs[7] = '{9, 11, 12, 9, 11, 10, 9};
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 7; t++) begin
      for (int k = 1; k <= ivs[t]; k++) begin
        step(k == ivs[t], 1'b1, 1'b0);
        checks++;
        if (obs0 !== exp0 || obs1 !== exp1) begin
          errors++;
          $display("FAIL tol t=%0t dut0=%h ref0=%h dut1=%h ref1=%h", $time, obs0, exp0, obs1, exp1);
        end
      end
      if (t == 2 || t == 5) begin
        checks++;
        if (bus1.locked !== 1'b0 || bus1.fault !== 1'b0) begin
          errors++;
          $display("FAIL tol_unlocked idx=%0d locked=%b fault=%b required 0 0", t, bus1.locked, bus1.fault);
        end
      end
    end
    checks++;
    if (bus1.locked !== 1'b1 || bus1.period !== 16'd9) begin
      errors++;
      $display("FAIL tol_lock locked=%b period=%0d required 1 9", bus1.locked, bus1.period);
    end
  endtask

  task automatic test_enable_drop();
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      for (int k = 1; k <= 10; k++) begin
        step(k == 10 || (t == 2 && k == 5), !(t == 2 && k >= 4 && k <= 6), 1'b0);
        checks++;
        if (obs0 !== exp0 || obs1 !== exp1) begin
          errors++;
          $display("FAIL endrop t=%0t dut0=%h ref0=%h dut1=%h ref1=%h", $time, obs0, exp0, obs1, exp1);
        end
        if (t == 2 && k == 6) begin
          checks++;
          if (bus0.period !== 16'd10 || bus0.period_valid !== 1'b0 || bus1.locked !== 1'b0) begin
            errors++;
            $display("FAIL endrop_idle period=%0d pv=%b locked1=%b required 10 0 0",
                     bus0.period, bus0.period_valid, bus1.locked);
          end
        end
        if (k == 10 && t >= 2) begin
          checks++;
          if (bus0.period_valid !== (t == 3)) begin
            errors++;
            $display("FAIL endrop_pv tick=%0d pv=%b required %b", t, bus0.period_valid, (t == 3));
          end
        end
      end
    end
  endtask

  task automatic test_clear_tick();
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 7; t++) begin
      for (int k = 1; k <= ((t == 4) ? 9 : 10); k++) begin
        step(k >= ((t == 4) ? 9 : 10), 1'b1, (t == 5 && k == 10));
        checks++;
        if (obs0 !== exp0 || obs1 !== exp1) begin
          errors++;
          $display("FAIL clrtick t=%0t dut0=%h ref0=%h dut1=%h ref1=%h", $time, obs0, exp0, obs1, exp1);
        end
      end
      if (t == 4 || t == 5) begin
        checks++;
        if (bus0.fault !== (t == 4) || (t == 5 && bus0.period_valid !== 1'b0)) begin
          errors++;
          $display("FAIL clrtick_state idx=%0d fault=%b pv=%b required fault %b pv 0", t, bus0.fault,
                   bus0.period_valid, (t == 4));
        end
      end
      if (t == 6) begin
        checks++;
        if (bus0.period_valid !== 1'b0 || bus0.locked !== 1'b0) begin
          errors++;
          $display("FAIL clrtick_first pv=%b locked=%b required 0 0", bus0.period_valid, bus0.locked);
        end
      end
    end
    step(1'b0, 1'b1, 1'b0);
    for (int k = 2; k <= 10; k++) step(k == 10, 1'b1, 1'b0);
    checks++;
    if (bus0.period_valid !== 1'b1 || bus0.period !== 16'd10) begin
      errors++;
      $display("FAIL clrtick_track pv=%b period=%0d required 1 10", bus0.period_valid, bus0.period);
    end
  endtask

  task automatic test_back_to_back();
    exp_b = 16'd1;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        errors++;
        $display("FAIL b2b t=%0t dut0=%h ref0=%h dut1=%h ref1=%h", $time, obs0, exp0, obs1, exp1);
      end
    end
    checks++;
    if (bus0.period !== 16'd1 || bus0.period_valid !== 1'b1 || bus0.locked !== 1'b1) begin
      errors++;
      $display("FAIL b2b_lock period=%0d pv=%b locked=%b required 1 1 1", bus0.period, bus0.period_valid, bus0.locked);
    end
  endtask

  task automatic test_random();
    int gap = 10;
    bit tk, en, clr;
    exp_b = 16'd10;
    for (int i = 0; i < 2500; i++) begin
      gap--;
      tk = (gap == 0);
      if (tk) gap = ($urandom_range(19, 0) == 0) ? 1 : int'($urandom_range(13, 8));
      en  = ($urandom_range(99, 0) >= 3);
      clr = ($urandom_range(99, 0) < 2);
      if ($urandom_range(199, 0) == 0) exp_b = 16'($urandom_range(11, 9));
      step(tk, en, clr);
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        errors++;
        $display("FAIL random t=%0t dut0=%h ref0=%h dut1=%h ref1=%h", $time, obs0, exp0, obs1, exp1);
      end
    end
  endtask

  initial begin
    reset = 1'b0; en_b = 1'b0; clr_b = 1'b0; tk_b = 1'b0; exp_b = 16'd10;
    #1 reset = 1'b1;
    test_reset();
    test_lock();
    test_early();
    test_timeout();
    test_tol();
    test_enable_drop();
    test_clear_tick();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
- Receive-side checker for periodic single-cycle tick strobes, such as the max_tick output of a free-running modulo counter.
- Measures the clock count between consecutive ticks and compares it against an expected period with a tolerance window.
- Declares lock after a run of good periods, and flags missing, early or late ticks.
- Sits beside a tick generator as a built-in health monitor for timebases.

Parameters:
- WIDTH, 16: width of the interval counter, expected and period.
- LOCK_CNT, 4: consecutive in-window periods required to assert locked (range 1..255).
- TOL, 0: allowed deviation in clocks; window is [expected-TOL, expected+TOL].

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  monitor enable; low forces IDLE.
- tick_in  in  1  single-cycle tick strobe from the generator.
- expected  in  WIDTH  expected period in clocks (generator max_count+1).
- clear  in  1  synchronous pulse; clears fault and restarts acquisition.
- period  out  WIDTH  last measured period in clocks; held between updates.
- period_valid  out  1  one-cycle pulse when period is updated.
- locked  out  1  high while in LOCKED.
- fault  out  1  sticky error flag, high in FAULT.
- timeout  out  1  one-cycle pulse when an interval exceeds expected+TOL with no tick.

Behaviour:
- Reset values: state IDLE, interval counter cnt=0, good_cnt=0, period=0; period_valid, locked, fault and timeout all 0.
- Interval counter:
  - On an accepted tick, cnt<=0; otherwise cnt<=cnt+1.
  - cnt saturates at 2^WIDTH-1 and does not wrap.
  - Measured P = cnt+1 at the tick cycle, so ticks at cycles t0 and t0+P give period P.
- Arithmetic: window bounds computed in WIDTH+1 bits.
  - Low bound = expected-TOL, saturating at 0.
  - High bound = expected+TOL, with no overflow.
- period/period_valid: registered one cycle after the tick. Updated for every tick in TRACK, LOCKED and FAULT. Not updated for the first tick in ACQUIRE, since there is no reference.
- timeout: pulses once per interval, in the cycle cnt+1 first equals high+1. No repeat until the next tick.
- States and transitions:
  - IDLE:
    - Ticks are ignored and cnt is held at 0.
    - enable=1 -> ACQUIRE.
  - ACQUIRE:
    - Waits for the first tick; timeout is suppressed.
    - tick -> TRACK with cnt=0 and good_cnt=0.
  - TRACK:
    - In-window tick: good_cnt+1. When good_cnt reaches LOCK_CNT -> LOCKED.
    - Out-of-window tick: good_cnt=0, stay in TRACK.
    - timeout -> ACQUIRE.
  - LOCKED:
    - In-window tick: stay.
    - Out-of-window tick or timeout -> FAULT; fault=1 and locked=0 in the same registered cycle.
  - FAULT:
    - Keeps measuring and reporting period; fault stays 1.
    - Exit only via clear or enable=0.
- Priority: enable=0 beats clear, which beats tick.
  - enable=0 in any state -> IDLE next cycle; clears fault, locked, cnt and good_cnt; period is held.
  - clear=1 (with enable=1) in any non-IDLE state -> ACQUIRE; clears fault, locked and good_cnt. A tick in the same cycle is ignored.
- expected is sampled combinationally every cycle; a change takes effect at the next comparison, with no resynchronisation.
- Back-to-back ticks, one per cycle, measure P=1.

Optional Feature:
- Macro: TICK_MINMAX_EN.
- Defined:
  - Adds output ports period_min and period_max, each WIDTH bits.
  - Both update with every period_valid.
  - Reset and clear set period_min to all-ones and period_max to 0.
- Undefined:
  - Ports and registers are absent; all other behaviour is identical.

Test Plan:
- WIDTH=16, TOL=0, LOCK_CNT=4, expected=10, ticks every 10 clocks:
  - period_valid pulses with period=10, one cycle after each tick from the 2nd tick.
  - locked rises after the 5th tick.
- Locked, then one tick arrives at interval 9:
  - period=9, FAULT, fault=1, locked=0.
  - clear pulse -> fault=0, reacquires, relocks after 5 more good ticks.
- Locked, ticks stop:
  - timeout pulses exactly 11 clocks after the last tick, only once.
  - fault=1.
- TOL=1, expected=10, intervals 9, 11, 10, 9:
  - All in window; locked after the 4th measured period.
  - Interval 12 in TRACK resets good_cnt; no fault.
- enable dropped mid-TRACK for 3 cycles, ticks continuing:
  - IDLE, outputs cleared, period held.
  - After re-enable, the first tick produces no period_valid.
- Simultaneous clear and tick while in FAULT:
  - ACQUIRE entered, tick ignored, no period_valid.
  - The next tick starts TRACK.
